csr_timer: RTL and testbench

- Constant-timer and stable-counter unit that sits directly upstream of the CSR register file.
- Holds the timer CSRs TID (0x40), TCFG (0x41), TVAL (0x42) and TICLR (0x44).
- Produces the timer interrupt that the CSR file samples into ESTAT.IS[11].
- Also provides a free-running 64-bit stable counter for the RDCNT instructions.
- Shares the instruction CSR access bus with the CSR file; read data is returned combinationally and merged at the top level.

---
 rtl/csr_timer_if.sv | 30 +++
 rtl/csr_timer.sv | 140 ++++++++++++++
 tb/tb_csr_timer.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_timer_if.sv
// ---------------------------------------------------------------------------
// csr_timer_if
//   Instruction-side CSR access bus shared by the CSR file and the timer unit.
//   The pipeline (or a testbench) drives the master side; csr_timer is a slave.
//
//   csr_num     14  CSR address
//   csr_we       1  write enable
//   csr_wmask   32  per-bit write mask
//   csr_wvalue  32  write data
//   csr_hit      1  slave claims the address
//   csr_rvalue  32  combinational read data from the slave (0 when not hit)
// ---------------------------------------------------------------------------
interface csr_timer_if;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        csr_hit;
    logic [31:0] csr_rvalue;

    modport master (
        output csr_num, csr_we, csr_wmask, csr_wvalue,
        input  csr_hit, csr_rvalue
    );

    modport slave (
        input  csr_num, csr_we, csr_wmask, csr_wvalue,
        output csr_hit, csr_rvalue
    );
endinterface

// File: rtl/csr_timer.sv
// ---------------------------------------------------------------------------
// csr_timer
//   Constant timer (TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44) plus the
//   64-bit stable counter read by RDCNT. Sits next to the CSR file on the
//   same access bus; read data is combinational and merged at the top level.
//
//   Parameters
//     COREID    reset value of TID
//     INIT_MIN  low two bits appended to TCFG.InitVal on reload
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   synchronous, active-high reset
//     bus        --   csr_timer_if.slave (num/we/wmask/wvalue in, hit/rvalue out)
//     timer_int  out  level interrupt to ESTAT.IS[11]
//     cnt_value  out  stable counter value
//     cnt_id     out  current TID, for RDCNTID
// ---------------------------------------------------------------------------
module csr_timer #(
    parameter logic [31:0] COREID   = 32'h0,
    parameter logic [1:0]  INIT_MIN = 2'b00
) (
    input  logic              clk,
    input  logic              reset,
    csr_timer_if.slave        bus,
    output logic              timer_int,
    output logic [63:0]       cnt_value,
    output logic [31:0]       cnt_id
);

    localparam logic [13:0] ADDR_TID   = 14'h40;
    localparam logic [13:0] ADDR_TCFG  = 14'h41;
    localparam logic [13:0] ADDR_TVAL  = 14'h42;
    localparam logic [13:0] ADDR_TICLR = 14'h44;

    // Architectural state
    logic [31:0] tid_q;
    logic        tcfg_en_q;
    logic        tcfg_periodic_q;
    logic [29:0] tcfg_initval_q;
    logic [31:0] tval_q;
    logic        timer_int_q;
    logic [63:0] stable_cnt;

    // Decode and next-state values
    logic        sel_tid, sel_tcfg, sel_tval, sel_ticlr;
    logic        wr_tid, wr_tcfg, ticlr_fire;
    logic [31:0] tcfg_rd;
    logic [31:0] tid_masked;
    logic [31:0] tcfg_masked;
    logic        tval_expired;
    logic [31:0] tval_nxt;

    assign tcfg_rd = {tcfg_initval_q, tcfg_periodic_q, tcfg_en_q};

    always_comb begin
        sel_tid   = (bus.csr_num == ADDR_TID);
        sel_tcfg  = (bus.csr_num == ADDR_TCFG);
        sel_tval  = (bus.csr_num == ADDR_TVAL);
        sel_ticlr = (bus.csr_num == ADDR_TICLR);

        wr_tid     = bus.csr_we & sel_tid;
        wr_tcfg    = bus.csr_we & sel_tcfg;
        ticlr_fire = bus.csr_we & sel_ticlr & bus.csr_wmask[0] & bus.csr_wvalue[0];

        tid_masked  = (bus.csr_wmask & bus.csr_wvalue) | (~bus.csr_wmask & tid_q);
        tcfg_masked = (bus.csr_wmask & bus.csr_wvalue) | (~bus.csr_wmask & tcfg_rd);

        tval_expired = tcfg_en_q && (tval_q == 32'h0);
    end

    // TVAL next-state. A TCFG write owns the cycle: post-mask En=1 reloads
    // from the freshly written InitVal, En=0 freezes the count where it is.
    always_comb begin
        // NOTE: default assignment first so every path drives tval_nxt; without it
        // the missing else-branches would infer a latch.
        tval_nxt = tval_q;
        if (wr_tcfg) begin
            if (tcfg_masked[0]) begin
                tval_nxt = {tcfg_masked[31:2], INIT_MIN};
            end
        end else if (tcfg_en_q) begin
            if (tval_q == 32'h0 && tcfg_periodic_q) begin
                tval_nxt = {tcfg_initval_q, INIT_MIN};
            end else if (tval_q != 32'hFFFF_FFFF) begin
                // One-shot expiry steps 0 -> FFFF_FFFF here and then parks.
                tval_nxt = tval_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            tid_q           <= COREID;
            tcfg_en_q       <= 1'b0;
            tcfg_periodic_q <= 1'b0;
            tcfg_initval_q  <= 30'h0;
            tval_q          <= 32'hFFFF_FFFF;
            timer_int_q     <= 1'b0;
            stable_cnt      <= 64'h0;
        end else begin
            if (wr_tid) begin
                tid_q <= tid_masked;
            end
            if (wr_tcfg) begin
                tcfg_en_q       <= tcfg_masked[0];
                tcfg_periodic_q <= tcfg_masked[1];
                tcfg_initval_q  <= tcfg_masked[31:2];
            end
            tval_q <= tval_nxt;

            // Expiry takes priority over the clear so a simultaneous event is kept.
            if (tval_expired) begin
                timer_int_q <= 1'b1;
            end else if (ticlr_fire) begin
                timer_int_q <= 1'b0;
            end

            stable_cnt <= stable_cnt + 64'd1;
        end
    end

    // Read mux reflects pre-write state; TICLR is write-only and reads 0.
    always_comb begin
        bus.csr_hit = sel_tid | sel_tcfg | sel_tval | sel_ticlr;
        case (1'b1)
            sel_tid:  bus.csr_rvalue = tid_q;
            sel_tcfg: bus.csr_rvalue = tcfg_rd;
            sel_tval: bus.csr_rvalue = tval_q;
            default:  bus.csr_rvalue = 32'h0;
        endcase
    end

    assign timer_int = timer_int_q;
    assign cnt_value = stable_cnt;
    assign cnt_id    = tid_q;

endmodule

// File: tb/tb_csr_timer.sv
// ---------------------------------------------------------------------------
// tb_csr_timer
//   Directed bench for csr_timer. Inputs change just after the falling edge,
//   outputs are sampled there too, so each rising edge sits mid-window.
// ---------------------------------------------------------------------------
module tb_csr_timer;

    localparam logic [31:0] TB_COREID = 32'h5A5A_0001;

    logic        clk;
    logic        reset;
    logic        timer_int;
    logic [63:0] cnt_value;
    logic [31:0] cnt_id;

    int checks = 0;
    int errors = 0;

    csr_timer_if bus ();

    csr_timer #(
        .COREID   (TB_COREID),
        .INIT_MIN (2'b00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .timer_int (timer_int),
        .cnt_value (cnt_value),
        .cnt_id    (cnt_id)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive a write in the current low phase; returns just after the next
    // falling edge, i.e. one cycle after the write edge has taken effect.
    task automatic write_csr(input logic [13:0] num, input logic [31:0] mask,
                             input logic [31:0] val);
        bus.csr_num    = num;
        bus.csr_wmask  = mask;
        bus.csr_wvalue = val;
        bus.csr_we     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.csr_we     = 1'b0;
        bus.csr_wmask  = 32'h0;
        bus.csr_wvalue = 32'h0;
    endtask

    task automatic read_csr(input logic [13:0] num, output logic [31:0] val);
        bus.csr_num = num;
        #1;
        val = bus.csr_rvalue;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset          = 1'b1;
        bus.csr_we     = 1'b0;
        bus.csr_num    = 14'h0;
        bus.csr_wmask  = 32'h0;
        bus.csr_wvalue = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        checks++;
        if (cnt_value !== 64'h0) begin
            errors++; $display("FAIL reset_cnt got %h exp %h", cnt_value, 64'h0);
        end
        checks++;
        if (timer_int !== 1'b0) begin
            errors++; $display("FAIL reset_int got %b exp 0", timer_int);
        end
        checks++;
        if (cnt_id !== TB_COREID) begin
            errors++; $display("FAIL reset_cnt_id got %h exp %h", cnt_id, TB_COREID);
        end
        read_csr(14'h40, v);
        checks++;
        if (v !== TB_COREID) begin
            errors++; $display("FAIL reset_tid got %h exp %h", v, TB_COREID);
        end
        read_csr(14'h41, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL reset_tcfg got %h exp 0", v);
        end
        read_csr(14'h42, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_tval got %h exp ffffffff", v);
        end
        read_csr(14'h44, v);
        checks++;
        if (v !== 32'h0 || bus.csr_hit !== 1'b1) begin
            errors++; $display("FAIL reset_ticlr got %h hit %b exp 0 hit 1", v, bus.csr_hit);
        end
        @(negedge clk);
        checks++;
        if (cnt_value !== 64'h1) begin
            errors++; $display("FAIL cnt_step got %h exp 1", cnt_value);
        end
    endtask

    // InitVal=4, En=1, one-shot: TVAL 0x10..0, interrupt 17 edges after write.
    task automatic test_oneshot();
        logic [31:0] v;
        write_csr(14'h41, 32'hFFFF_FFFF, 32'h0000_0011);
        read_csr(14'h42, v);
        checks++;
        if (v !== 32'h10) begin
            errors++; $display("FAIL oneshot_load got %h exp 10", v);
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            read_csr(14'h42, v);
            checks++;
            if (v !== 32'(16 - k) || timer_int !== 1'b0) begin
                errors++;
                $display("FAIL oneshot_count k=%0d got tval %h int %b exp tval %h int 0",
                         k, v, timer_int, 32'(16 - k));
            end
        end
        @(negedge clk);
        read_csr(14'h42, v);
        checks++;
        if (timer_int !== 1'b1 || v !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL oneshot_expire got int %b tval %h exp int 1 tval ffffffff", timer_int, v);
        end
        repeat (3) @(negedge clk);
        read_csr(14'h42, v);
        checks++;
        if (timer_int !== 1'b1 || v !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL oneshot_hold got int %b tval %h exp int 1 tval ffffffff", timer_int, v);
        end
        read_csr(14'h41, v);
        checks++;
        if (v !== 32'h11) begin
            errors++; $display("FAIL oneshot_tcfg got %h exp 11", v);
        end
    endtask

    // Reload 8, periodic: expiries every 9 edges; TICLR drops the level.
    task automatic test_periodic();
        logic [31:0] v;
        write_csr(14'h44, 32'h1, 32'h1);
        checks++;
        if (timer_int !== 1'b0) begin
            errors++; $display("FAIL ticlr_clear got %b exp 0", timer_int);
        end
        write_csr(14'h41, 32'hFFFF_FFFF, 32'h0000_000B);
        read_csr(14'h42, v);
        checks++;
        if (v !== 32'h8) begin
            errors++; $display("FAIL periodic_load got %h exp 8", v);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            read_csr(14'h42, v);
            checks++;
            if (v !== 32'(8 - k) || timer_int !== 1'b0) begin
                errors++;
                $display("FAIL periodic_count1 k=%0d got tval %h int %b exp tval %h int 0",
                         k, v, timer_int, 32'(8 - k));
            end
        end
        @(negedge clk);
        read_csr(14'h42, v);
        checks++;
        if (timer_int !== 1'b1 || v !== 32'h8) begin
            errors++;
            $display("FAIL periodic_expire1 got int %b tval %h exp int 1 tval 8", timer_int, v);
        end
        write_csr(14'h44, 32'h1, 32'h1);
        read_csr(14'h42, v);
        checks++;
        if (timer_int !== 1'b0 || v !== 32'h7) begin
            errors++;
            $display("FAIL periodic_clear got int %b tval %h exp int 0 tval 7", timer_int, v);
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            read_csr(14'h42, v);
            checks++;
            if (v !== 32'(7 - k) || timer_int !== 1'b0) begin
                errors++;
                $display("FAIL periodic_count2 k=%0d got tval %h int %b exp tval %h int 0",
                         k, v, timer_int, 32'(7 - k));
            end
        end
        @(negedge clk);
        read_csr(14'h42, v);
        checks++;
        if (timer_int !== 1'b1 || v !== 32'h8) begin
            errors++;
            $display("FAIL periodic_expire2 got int %b tval %h exp int 1 tval 8", timer_int, v);
        end
    endtask

    // TICLR written in the very cycle TVAL==0: the expiry must survive.
    task automatic test_set_wins();
        logic [31:0] v;
        write_csr(14'h44, 32'h1, 32'h1);
        checks++;
        if (timer_int !== 1'b0) begin
            errors++; $display("FAIL setwins_preclear got %b exp 0", timer_int);
        end
        repeat (7) @(negedge clk);
        read_csr(14'h42, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL setwins_at_zero got %h exp 0", v);
        end
        write_csr(14'h44, 32'h1, 32'h1);
        read_csr(14'h42, v);
        checks++;
        if (timer_int !== 1'b1 || v !== 32'h8) begin
            errors++;
            $display("FAIL setwins got int %b tval %h exp int 1 tval 8", timer_int, v);
        end
    endtask

    // En cleared mid-count freezes TVAL; TVAL is read-only; TID writable;
    // addresses outside the block are ignored.
    task automatic test_freeze_and_ro();
        logic [31:0] v;
        write_csr(14'h44, 32'h1, 32'h1);
        repeat (2) @(negedge clk);
        read_csr(14'h42, v);
        checks++;
        if (v !== 32'h5 || timer_int !== 1'b0) begin
            errors++;
            $display("FAIL freeze_pre got tval %h int %b exp tval 5 int 0", v, timer_int);
        end
        write_csr(14'h41, 32'h1, 32'h0);
        read_csr(14'h41, v);
        checks++;
        if (v !== 32'h0000_000A) begin
            errors++; $display("FAIL freeze_tcfg got %h exp a", v);
        end
        for (int k = 0; k < 12; k++) begin
            read_csr(14'h42, v);
            checks++;
            if (v !== 32'h5 || timer_int !== 1'b0) begin
                errors++;
                $display("FAIL freeze_hold k=%0d got tval %h int %b exp tval 5 int 0",
                         k, v, timer_int);
            end
            @(negedge clk);
        end
        write_csr(14'h42, 32'hFFFF_FFFF, 32'h0000_1234);
        read_csr(14'h42, v);
        checks++;
        if (v !== 32'h5) begin
            errors++; $display("FAIL tval_readonly got %h exp 5", v);
        end
        write_csr(14'h40, 32'hFFFF_FFFF, 32'h0000_ABCD);
        checks++;
        if (cnt_id !== 32'h0000_ABCD) begin
            errors++; $display("FAIL tid_write got %h exp abcd", cnt_id);
        end
        write_csr(14'h40, 32'h0000_FF00, 32'h1234_5678);
        read_csr(14'h40, v);
        checks++;
        if (v !== 32'h0000_56CD) begin
            errors++; $display("FAIL tid_masked got %h exp 56cd", v);
        end
        write_csr(14'h43, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        read_csr(14'h43, v);
        checks++;
        if (v !== 32'h0 || bus.csr_hit !== 1'b0) begin
            errors++; $display("FAIL unmapped got %h hit %b exp 0 hit 0", v, bus.csr_hit);
        end
        read_csr(14'h41, v);
        checks++;
        if (v !== 32'h0000_000A || cnt_id !== 32'h0000_56CD) begin
            errors++;
            $display("FAIL unmapped_side_effect got tcfg %h tid %h exp a 56cd", v, cnt_id);
        end
    endtask

    task automatic test_counter_wrap();
        @(negedge clk);
        force dut.stable_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.stable_cnt;
        #1;
        checks++;
        if (cnt_value !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++; $display("FAIL wrap_preload got %h exp fffffffffffffffe", cnt_value);
        end
        @(negedge clk);
        checks++;
        if (cnt_value !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL wrap_max got %h exp ffffffffffffffff", cnt_value);
        end
        @(negedge clk);
        checks++;
        if (cnt_value !== 64'h0) begin
            errors++; $display("FAIL wrap_zero got %h exp 0", cnt_value);
        end
        @(negedge clk);
        checks++;
        if (cnt_value !== 64'h1) begin
            errors++; $display("FAIL wrap_one got %h exp 1", cnt_value);
        end
    endtask

    task automatic test_reset_mid_count();
        logic [31:0] v;
        // InitVal=0, En=1: TVAL loads 0 and the next edge raises the interrupt.
        write_csr(14'h41, 32'hFFFF_FFFF, 32'h0000_0001);
        @(negedge clk);
        checks++;
        if (timer_int !== 1'b1) begin
            errors++; $display("FAIL pre_reset_int got %b exp 1", timer_int);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (timer_int !== 1'b0 || cnt_value !== 64'h0 || cnt_id !== TB_COREID) begin
            errors++;
            $display("FAIL midreset_outputs got int %b cnt %h id %h exp 0 0 %h",
                     timer_int, cnt_value, cnt_id, TB_COREID);
        end
        read_csr(14'h42, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL midreset_tval got %h exp ffffffff", v);
        end
        read_csr(14'h41, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL midreset_tcfg got %h exp 0", v);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (timer_int !== 1'b0 || cnt_value !== 64'h3) begin
            errors++;
            $display("FAIL postreset got int %b cnt %h exp int 0 cnt 3", timer_int, cnt_value);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_set_wins();
        test_freeze_and_ro();
        test_counter_wrap();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
